// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Purpose  : Shared state encoding, default sizing and detector pattern.
// Revision : 1.0
// ============================================================================
package seq_det_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t DONE  = 2'd3;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_CNT_W   = 4;
    localparam int DEF_DET_LAT = 1;

    localparam logic [2:0] PATTERN = 3'b110;

    // Cycle counter must reach WIDTH+DET_LAT-1 without wrapping.
    function automatic int cnt_width(input int width, input int det_lat);
        return $clog2(width + det_lat + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Purpose  : Parallel-load shift register, MSB-first serial output, 0 shifted in.
// Revision : 1.0
// ============================================================================
module bit_serializer
    import seq_det_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] r_sreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
        end else if (load) begin
            r_sreg <= din;
        end else if (shift) begin
            r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign sout = r_sreg[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_ctrl
// Purpose  : Serializes a job word into a Seq_Det instance and counts its hits.
// Revision : 1.0
// ============================================================================
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DET_LAT = DEF_DET_LAT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hits,
    output logic             det_b,
    output logic             det_rst,
    input  logic             det_w
);

    localparam int CW = cnt_width(WIDTH, DET_LAT);

    localparam logic [CW-1:0]    C_SHIFT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    C_WIN_FIRST  = CW'(DET_LAT);
    localparam logic [CW-1:0]    C_WIN_LAST   = CW'(WIDTH + DET_LAT - 1);
    localparam logic [CNT_W-1:0] C_HIT_MAX    = '1;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            w_accept;
    logic            w_shift;
    logic            w_in_window;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_shift     = (r_state == SHIFT);
    assign w_in_window = ((r_state == SHIFT) || (r_state == DRAIN)) &&
                         (r_cnt >= C_WIN_FIRST) && (r_cnt <= C_WIN_LAST);

    // The register drains to zero after WIDTH shifts, so its MSB is 0 in DRAIN/IDLE.
    bit_serializer #(
        .WIDTH (WIDTH)
    ) u_ser (
        .clk   (Clk),
        .rst_n (Rst),
        .load  (w_accept),
        .shift (w_shift),
        .din   (data),
        .sout  (det_b)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            hits    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            det_rst <= 1'b1;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SHIFT;
                        r_cnt   <= '0;
                        hits    <= '0;
                        busy    <= 1'b1;
                        det_rst <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_SHIFT_LAST) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_WIN_LAST) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        det_rst <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (w_in_window && det_w && (hits != C_HIT_MAX)) begin
                hits <= hits + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
# seq_det_ctrl

Sequencing controller for the `Seq_Det` serial sequence detector. It accepts a parallel word on a start handshake, holds the detector in reset while idle, releases it and serializes the word MSB-first onto the detector's `B` input, and counts the detector's `w` pulses. It reports a saturating hit count with a one-cycle `done` pulse. It sits between a parallel requester and one `Seq_Det` instance, driving that instance's `B` and `Rst` pins.

## Interface
- `WIDTH`, 8: bits per job.
- `CNT_W`, 4: hit-counter width.
- `DET_LAT`, 1: detector latency, in cycles from the edge consuming a bit to `w` valid. Range is 1..4.

- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; accepted only in IDLE.
- `data`  in  WIDTH  job word; sampled on the accepting edge.
- `busy`  out  1  high from the accepting edge until `done` has been issued.
- `done`  out  1  one-cycle completion pulse.
- `hits`  out  CNT_W  detection count of the last job; held until the next accept.
- `det_b`  out  1  serial bit to detector `B`.
- `det_rst`  out  1  active-high detector reset, to detector `Rst`.
- `det_w`  in  1  detector output `w`.

## Operation
- **Reset** (`Rst`=0): state IDLE, shift register 0, cycle counter 0, `hits`=0, `busy`=0, `done`=0, `det_b`=0, `det_rst`=1.
- **IDLE**
  - `det_rst`=1, `det_b`=0.
  - On `start`=1: latch `data`, clear `hits` and the counter, go to SHIFT.
- **SHIFT**, WIDTH cycles
  - `det_rst`=0; `det_b` = shift-register MSB.
  - Each edge shifts the register left (0 in) and increments the counter.
  - After WIDTH cycles, go to DRAIN.
- **DRAIN**, DET_LAT cycles: `det_rst`=0, `det_b`=0, counter keeps incrementing. Then go to DONE.
- **DONE**, 1 cycle: `done`=1, `busy`=0, `det_rst`=1. Then go to IDLE.
- **Hit window**
  - Cycles are indexed from 0 at the first SHIFT cycle.
  - `det_w` is sampled on the edges ending cycles DET_LAT through WIDTH+DET_LAT-1, which is exactly WIDTH samples.
  - Each sample with `det_w`=1 increments `hits`.
  - `det_w` outside this window is ignored. A match completed by a DRAIN zero is therefore not counted.
- **Arithmetic**: `hits` saturates at 2^CNT_W-1 and never wraps. The counter width is clog2(WIDTH+DET_LAT+1).
- **Ignored start**: `start` in SHIFT, DRAIN or DONE is dropped. There is no queueing, and `data` is not re-sampled.
- **Mid-job reset**: asynchronous return to the reset values above. `det_rst` rises immediately and `done` is never issued for the aborted job.

## Timing
- Accept edge at cycle n: SHIFT occupies n+1 through n+WIDTH, and the first `det_b` bit is valid in cycle n+1.
- `done` is high in cycle n+WIDTH+DET_LAT+1. Latency from accept to `done` is WIDTH+DET_LAT+1 cycles.
- `busy` is high in cycles n+1 through n+WIDTH+DET_LAT and low during DONE.
- `hits` is final when `done` is high. It may change during SHIFT and DRAIN.
- Back-to-back jobs: the earliest next accept is the edge after DONE. Minimum job period is WIDTH+DET_LAT+2 cycles.
- All outputs are registered, with no combinational path from any input to any output.

## Structure
- Shared package `seq_det_pkg`:
  - state encoding localparams IDLE/SHIFT/DRAIN/DONE (2 bits);
  - default WIDTH/CNT_W/DET_LAT constants;
  - the 3-bit target pattern `3'b110`, used by the bench model.
- One sub-module, `bit_serializer`: parallel load, MSB-first shift, `load`/`shift` enables, and a serial output.
- The FSM, cycle counter and saturating hit counter live in `seq_det_ctrl`.

## Test plan
Bench setup: a behavioural Moore "110" detector with DET_LAT=1, driven by `det_b` and `det_rst`. Defaults apply unless stated.

- **Reset values**: hold `Rst`=0 for 3 cycles → `det_rst`=1, `busy`=0, `done`=0, `hits`=0. Release, then idle 5 cycles → outputs unchanged.
- **Basic job**: `data`=8'b1101_1000 with `start` for 1 cycle → `det_b` sequence 1,1,0,1,1,0,0,0; `done` 10 cycles after accept; `hits`=2.
- **No matches, boundary**
  - `data`=8'hFF → `hits`=0.
  - `data`=8'b1101_1011 → `hits`=2; the trailing "11" plus a DRAIN zero is not counted.
- **Saturation** (WIDTH=16, CNT_W=2): `data`=16'hDB6C gives 5 raw matches → `hits`=3, no wrap.
- **Start while busy**: second `start` with `data`=8'h00 at cycle 4 of a job → ignored; first job's `hits` is unaffected; exactly one `done`.
- **Reset mid-SHIFT**: assert `Rst`=0 at cycle 3 → immediate `det_rst`=1, `hits`=0, `busy`=0, no `done`. A fresh job with 8'b1101_1000 then returns `hits`=2.
